// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU opcodes and the multiply sequencer state encoding.
package mips_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    ADD,
    SHL,
    SHR,
    DONE
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier (low WIDTH bits) that borrows the shared EX-stage ALU for every step.
// ALU controls are registered on entry to each state, so alu_result is valid for the current state.
module alu_mul_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  seq_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] product;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      alu_op  <= ALU_ADD;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      // ALU controls idle at ADD 0+0 unless the next state needs them.
      done   <= 1'b0;
      alu_op <= ALU_ADD;
      alu_a  <= '0;
      alu_b  <= '0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mcand   <= op_a;
              mplier  <= op_b;
              product <= '0;
              count   <= '0;
              busy    <= 1'b1;
              state   <= EVAL;
            end
          end
          EVAL: begin
            if (mplier == '0 || count == CNT_W'(WIDTH)) begin
              result <= product;
              done   <= 1'b1;
              state  <= DONE;
            end else if (mplier[0]) begin
              alu_a <= product;
              alu_b <= mcand;
              state <= ADD;
            end else begin
              alu_op <= ALU_SLL;
              alu_a  <= mcand;
              alu_b  <= WIDTH'(1);
              state  <= SHL;
            end
          end
          ADD: begin
            product <= alu_result;
            alu_op  <= ALU_SLL;
            alu_a   <= mcand;
            alu_b   <= WIDTH'(1);
            state   <= SHL;
          end
          SHL: begin
            mcand  <= alu_result;
            alu_op <= ALU_SRL;
            alu_a  <= mplier;
            alu_b  <= WIDTH'(1);
            state  <= SHR;
          end
          SHR: begin
            mplier <= alu_result;
            count  <= count + CNT_W'(1);
            state  <= EVAL;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, table vectors, random operands vs. a product/latency model.
module tb_alu_mul_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;

  int vectors = 0;
  int miscompares = 0;

  alu_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Purely combinational EX-stage ALU.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_SLL: alu_result = alu_a << alu_b[4:0];
      ALU_SRL: alu_result = alu_a >> alu_b[4:0];
      ALU_SRA: alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [31:0] b);
    int k = 0;
    int p = 0;
    for (int i = 0; i < 32; i++) if (b[i]) begin p++; k = i + 1; end
    return 1 + 3 * k + p;
  endfunction

  // Opcode seen in each cycle from E0 up to the done cycle: ADD while deciding,
  // then ADD/SLL/SRL for a set multiplier bit, SLL/SRL for a clear one.
  function automatic bit trace_ok(input logic [31:0] b, input logic [3:0] obs[$]);
    logic [3:0] q[$];
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    q.push_back(ALU_ADD);
    for (int i = 0; i < k; i++) begin
      if (b[i]) q.push_back(ALU_ADD);
      q.push_back(ALU_SLL);
      q.push_back(ALU_SRL);
      q.push_back(ALU_ADD);
    end
    return q == obs;
  endfunction

  // Run one multiply from IDLE; optionally hammer start with junk operands while busy and in the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output logic [31:0] res, output int lat);
    logic [3:0] obs[$];
    int n = 0;
    int busy_low = 0;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {31'b0, busy}, 32'd1);
    while (!done && n < 300) begin
      obs.push_back(alu_op);
      if (!busy) busy_low++;
      if (noise) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("busy_in_op", busy_low, 0);
    if (noise) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
    lat = n;
    res = result;
    check("latency", lat, model_lat(b));
    check("result", res, a * b);
    check("alu_trace", {31'b0, trace_ok(b, obs)}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_1cyc", {31'b0, done}, 32'd0);
    check("busy_fall", {31'b0, busy}, 32'd0);
    if (noise) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("no_restart", {30'b0, busy, done}, 32'd0);
      end
      check("result_held", result, a * b);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [31:0] r;
    int          l;
    logic [31:0] prev;

    tbl[0] = '{32'd3,        32'd5,        32'd15,       12};
    tbl[1] = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 13};
    tbl[2] = '{32'h12345678, 32'd0,        32'd0,        1};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        129};
    tbl[4] = '{32'd6,        32'd7,        32'd42,       13};

    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0, r, l);
      check("tbl_result", r, tbl[i].exp_res);
      check("tbl_latency", l, tbl[i].exp_lat);
    end

    // start while busy and during done is ignored
    run_op(32'd3, 32'd5, 1'b1, r, l);

    // flush at cycle 4 of 7x9
    prev = result;
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    for (int i = 0; i < 40; i++) begin
      check("flush_no_done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    check("flush_result_kept", result, prev);
    run_op(32'd7, 32'd9, 1'b0, r, l);
    check("after_flush", r, 32'd63);

    // asynchronous reset mid-operation
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd6, 32'd7, 1'b0, r, l);
    check("after_rst", r, 32'd42);

    // random operands, including sparse and small multipliers
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = 32'd1 << $urandom_range(0, 31);
        default: b = $urandom & $urandom & $urandom;
      endcase
      run_op(a, b, (i % 8) == 7, r, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle multiply sequencer for the pipelined MIPS datapath. It computes the low 32 bits of a 32x32 product with shift-and-add, using the shared 4-bit-opcode ALU for every arithmetic step (ADD, SLL, SRL). It sits beside the EX stage, drives the ALU operand and opcode inputs, and reports completion with a one-cycle done pulse. The low 32 bits are identical for signed and unsigned operands, so one sequencer serves both MULT flavours.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort; returns to IDLE with no done pulse.
- op_a  input  WIDTH  multiplicand; captured on the accepting edge.
- op_b  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; high only in DONE.
- result  output  WIDTH  low WIDTH bits of op_a*op_b; held until the next accepted start.
- alu_a  output  WIDTH  ALU operand 1 (regData1).
- alu_b  output  WIDTH  ALU operand 2 (regData2).
- alu_op  output  4  ALU opcode.
- alu_result  input  WIDTH  combinational ALU result for the current alu_a/alu_b/alu_op.

## Operation
- Registers: mcand, mplier, product (WIDTH each), count (CNT_W), state.
- States and transitions:
  - IDLE: start=1 latches mcand=op_a, mplier=op_b, product=0, count=0, then goes to EVAL.
  - EVAL: if mplier==0 or count==WIDTH, go to DONE; else if mplier[0], go to ADD; else go to SHL.
  - ADD: alu_op=ADD, alu_a=product, alu_b=mcand, product<=alu_result, then SHL.
  - SHL: alu_op=SLL, alu_a=mcand, alu_b=1, mcand<=alu_result, then SHR.
  - SHR: alu_op=SRL, alu_a=mplier, alu_b=1, mplier<=alu_result, count+1, then EVAL.
  - DONE: result<=product on entry, so result is valid in the same cycle done is high; then IDLE.
- In IDLE, EVAL and DONE: alu_op=ADD, alu_a=0, alu_b=0.
- Width rule: ADD wraps modulo 2^WIDTH and bits shifted out of mcand are discarded. This gives low-word product semantics.
- start outside IDLE is ignored and not queued. start in the same cycle done is high is also ignored.
- flush has priority over start and state advance. From any state it goes to IDLE, result is unchanged and no done pulse is issued.
- Reset, including mid-operation: state=IDLE, busy=0, done=0, result=0, all internal registers 0, alu_op=ADD, alu_a=0, alu_b=0.

## Timing
- Accepting edge E0 is the edge at which start=1 is sampled in IDLE.
- busy rises after E0. done is high during the cycle after edge E0+L. busy falls one cycle later.
- L = 1 + 3k + p, where k = bit index of the most-significant 1 of op_b plus 1 (k=0 for op_b=0), and p = popcount(op_b).
- Bounds: minimum L=1 (op_b=0); maximum L=1+96+32=129 (op_b=0xFFFFFFFF).
- The earliest next start is accepted in the cycle after done.
- alu_result is sampled in the same cycle the opcode is driven. The ALU is purely combinational and has no pipeline register.

## Structure
- Shared package mips_pkg holds:
  - ALU opcode constants: ADD=4'b0000, SUB=4'b0010, AND=4'b0100, OR=4'b0101, NOR=4'b0110, XOR=4'b0111, SLL=4'b1000, SRL=4'b1001, SRA=4'b1010.
  - The sequencer state enum: IDLE, EVAL, ADD, SHL, SHR, DONE.
- No sub-module. The ALU is instantiated at the EX-stage level and its ports are wired to this block. The sequencer is one FSM plus datapath registers.

## Test plan
- op_a=3, op_b=5 -> result=15; done high exactly 12 cycles after E0; alu_op trace follows ADD,SLL,SRL,SLL,SRL,ADD,SLL,SRL.
- op_a=0xFFFFFFFD (-3), op_b=7 -> result=0xFFFFFFEB; L=13. op_a=0x12345678, op_b=0 -> result=0, L=1.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001; L=129; busy high for 129 cycles.
- Pulse start with new operands while busy and in the done cycle -> first result is unaffected, no second operation starts, and only one done pulse occurs.
- Assert flush at cycle 4 of a 7x9 operation -> IDLE next cycle, no done pulse, result keeps its previous value; a following 7x9 start gives 63.
- Drop rst_n mid-operation -> busy, done and result go to 0 and alu_op=ADD immediately; after release, 6x7 gives 42.
